// File: rtl/vr16_mem_arbiter.sv
// vr16_mem_arbiter
// Shares the single-port VR16 memory between the instruction-fetch port and
// the data load/store port. One transaction is outstanding at a time: a
// requester is granted in IDLE, the memory is strobed for one cycle, a
// fixed-latency wait follows, and the owner gets a one-cycle rvalid pulse.
//
// Optional build feature:
//   VR16_ARB_PERF_EN - adds if_stall_cnt / d_stall_cnt, 16-bit saturating
//                      counts of cycles where a port requested but was not
//                      granted.
module vr16_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2     // legal range 1..15
) (
  input  logic              global_clk,
  input  logic              global_reset,   // asynchronous, active-low
`ifdef VR16_ARB_PERF_EN
  output logic [15:0]       if_stall_cnt,
  output logic [15:0]       d_stall_cnt,
`endif
  // instruction-fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // data load/store port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Counter reload: the capture happens when the counter reaches zero, so
  // MEM_LAT-1 puts the capture exactly MEM_LAT cycles after the mem_en cycle.
  localparam logic [3:0] WAIT_LOAD = 4'(MEM_LAT - 1);

  state_t            state;
  state_t            state_nxt;
  logic              owner_d;        // 1 = data port owns the transaction
  logic              rr_data_first;  // round-robin pointer, 1 = data wins a tie
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wait_cnt;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              grant_any;

  // Arbitration and next-state logic; grants exist only in IDLE.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        // Grants are gated by reset so requesters never see a phantom
        // handshake while the block is held in reset.
        if (global_reset) begin
          if (d_req && (!if_req || rr_data_first)) begin
            d_gnt = 1'b1;
          end else if (if_req) begin
            if_gnt = 1'b1;
          end
        end
        if (if_gnt || d_gnt) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: state_nxt = WAIT;
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign grant_any = if_gnt | d_gnt;

  // State register.
  always_ff @(posedge global_clk or negedge global_reset) begin
    // NOTE: sequential state is written with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    if (!global_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Transaction latches and round-robin pointer, loaded on the grant edge.
  always_ff @(posedge global_clk or negedge global_reset) begin
    if (!global_reset) begin
      owner_d       <= 1'b0;
      rr_data_first <= 1'b1;
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
    end else if (grant_any) begin
      owner_d       <= d_gnt;
      // The port just served loses the next tie.
      rr_data_first <= if_gnt;
      addr_q        <= d_gnt ? d_addr : if_addr;
      we_q          <= d_gnt & d_we;
      wdata_q       <= d_gnt ? d_wdata : '0;
    end
  end

  // Latency counter: loaded leaving ACCESS, counts down through WAIT.
  always_ff @(posedge global_clk or negedge global_reset) begin
    if (!global_reset) begin
      wait_cnt <= 4'd0;
    end else if (state == ACCESS) begin
      wait_cnt <= WAIT_LOAD;
    end else if (state == WAIT && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Per-port read data registers; each holds until its port's next capture.
  always_ff @(posedge global_clk or negedge global_reset) begin
    if (!global_reset) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if (state == WAIT && wait_cnt == 4'd0) begin
      if (owner_d) begin
        // A store returns an acknowledge with zero data.
        d_rdata_q <= we_q ? '0 : mem_rdata;
      end else begin
        if_rdata_q <= mem_rdata;
      end
    end
  end

`ifdef VR16_ARB_PERF_EN
  // Saturating stall counters: cycles with a request but no grant.
  always_ff @(posedge global_clk or negedge global_reset) begin
    if (!global_reset) begin
      if_stall_cnt <= 16'h0000;
      d_stall_cnt  <= 16'h0000;
    end else begin
      if (if_req && !if_gnt && if_stall_cnt != 16'hFFFF) begin
        if_stall_cnt <= if_stall_cnt + 16'h0001;
      end
      if (d_req && !d_gnt && d_stall_cnt != 16'hFFFF) begin
        d_stall_cnt <= d_stall_cnt + 16'h0001;
      end
    end
  end
`else
  // Stall counters are not built; the arbiter behaves identically.
`endif

  // Memory strobe and response outputs decode straight from the state, so
  // an asynchronous reset drops them immediately.
  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state != IDLE);
  assign if_rvalid = (state == RESP) & ~owner_d;
  assign d_rvalid  = (state == RESP) &  owner_d;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule
